// File: rtl/jpeg_zigzag_pkg.sv
// Zigzag scan tables shared by the raster<->zigzag reorder stages.
// MCU_SIZE, ZZ_TO_RASTER (zigzag pos -> raster idx), RASTER_TO_ZZ (inverse).
package jpeg_zigzag_pkg;

  localparam int MCU_SIZE = 64;

  localparam logic [5:0] ZZ_TO_RASTER [MCU_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [5:0] RASTER_TO_ZZ [MCU_SIZE] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

endpackage

// File: rtl/matrix_to_zigzag_if.sv
// Write/read bundle of the raster-to-zigzag reorder stage.
// master: drives i_we/i_data/i_re; slave: drives o_* status and data.
interface matrix_to_zigzag_if #(
  parameter int DATA_W = 16
);
  logic              i_we;
  logic [DATA_W-1:0] i_data;
  logic              o_full;
  logic              i_re;
  logic              o_nempty;
  logic              o_dv;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              o_eob;

  modport master (
    output i_we, i_data, i_re,
    input  o_full, o_nempty, o_dv,
    input  o_data, o_last, o_eob
  );

  modport slave (
    input  i_we, i_data, i_re,
    output o_full, o_nempty, o_dv,
    output o_data, o_last, o_eob
  );
endinterface

// File: rtl/matrix_to_zigzag_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: i_sysclk, i_arst (clears read data only), we/waddr/wdata, re/raddr/rdata.
module simple_dual_port_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              i_sysclk,
  input  logic              i_arst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge i_sysclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/matrix_to_zigzag.sv
// Raster-order 8x8 blocks in, zigzag-order out, NUM_MATRIX ping-pong banks.
// Ports: i_sysclk, i_arst, bus (slave). Option: MATRIX_TO_ZIGZAG_EOB_EN.
module matrix_to_zigzag
  import jpeg_zigzag_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_MATRIX = 2
) (
  input logic               i_sysclk,
  input logic               i_arst,
  matrix_to_zigzag_if.slave bus
);
  localparam int BW = $clog2(NUM_MATRIX);
  localparam int AW = BW + 6;

  logic [BW-1:0]     wr_bank, rd_bank;
  logic [5:0]        wr_idx, rd_idx;
  logic [BW:0]       bank_cnt, cnt_nxt;
  logic              full_q, nempty_q;
  logic              dv_q, last_q, eob_q;
  logic              wr_ok, rd_ok;
  logic              commit, free;
  logic              eob_hit;
  logic [AW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] rdata;

  assign wr_ok  = bus.i_we && !full_q;
  assign rd_ok  = bus.i_re && nempty_q;
  assign commit = wr_ok && (wr_idx == 6'd63);
  assign free   = rd_ok && (rd_idx == 6'd63);
  assign waddr  = {wr_bank, wr_idx};
  assign raddr  = {rd_bank, ZZ_TO_RASTER[rd_idx]};

  always_comb begin
    cnt_nxt = bank_cnt;
    unique case ({commit, free})
      2'b10:   cnt_nxt = bank_cnt + 1'b1;
      2'b01:   cnt_nxt = bank_cnt - 1'b1;
      default: cnt_nxt = bank_cnt;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      wr_bank  <= '0;
      wr_idx   <= '0;
      rd_bank  <= '0;
      rd_idx   <= '0;
      bank_cnt <= '0;
      full_q   <= 1'b0;
      nempty_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_idx <= wr_idx + 6'd1;
        if (commit) wr_bank <= wr_bank + 1'b1;
      end
      if (rd_ok) begin
        rd_idx <= rd_idx + 6'd1;
        if (free) rd_bank <= rd_bank + 1'b1;
      end
      bank_cnt <= cnt_nxt;
      full_q   <= (cnt_nxt == (BW+1)'(NUM_MATRIX));
      nempty_q <= (cnt_nxt != '0);
    end
  end

`ifdef MATRIX_TO_ZIGZAG_EOB_EN
  // Highest zigzag position holding a nonzero value, per bank.
  logic [5:0] last_nz [NUM_MATRIX];
  logic [5:0] wr_zz;

  assign wr_zz = RASTER_TO_ZZ[wr_idx];

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      for (int b = 0; b < NUM_MATRIX; b++)
        last_nz[b] <= '0;
    end else if (wr_ok) begin
      if (wr_idx == 6'd0)
        last_nz[wr_bank] <= '0;
      else if (bus.i_data != '0 && wr_zz > last_nz[wr_bank])
        last_nz[wr_bank] <= wr_zz;
    end
  end

  assign eob_hit = rd_ok && (rd_idx == last_nz[rd_bank]);
`else
  assign eob_hit = 1'b0;
`endif

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      dv_q   <= 1'b0;
      last_q <= 1'b0;
      eob_q  <= 1'b0;
    end else begin
      dv_q   <= rd_ok;
      last_q <= free;
      eob_q  <= eob_hit;
    end
  end

  simple_dual_port_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_ram (
    .i_sysclk (i_sysclk),
    .i_arst   (i_arst),
    .we       (wr_ok),
    .waddr    (waddr),
    .wdata    (bus.i_data),
    .re       (rd_ok),
    .raddr    (raddr),
    .rdata    (rdata)
  );

  assign bus.o_full   = full_q;
  assign bus.o_nempty = nempty_q;
  assign bus.o_dv     = dv_q;
  assign bus.o_data   = rdata;
  assign bus.o_last   = last_q;
  assign bus.o_eob    = eob_q;
endmodule

// File: tb/tb_matrix_to_zigzag.sv
// Bench for matrix_to_zigzag: block-level queue model plus directed cases.
// Build with or without MATRIX_TO_ZIGZAG_EOB_EN.
module tb_matrix_to_zigzag;
  localparam int DW = 16;
  localparam int NM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_to_zigzag_if #(.DATA_W(DW)) bus ();

  matrix_to_zigzag #(
    .DATA_W     (DW),
    .NUM_MATRIX (NM)
  ) dut (
    .i_sysclk (clk),
    .i_arst   (rst),
    .bus      (bus)
  );

  typedef int blk_t [64];

  blk_t store[$];
  blk_t cur;
  int   wi, ri;
  int   zz_order [64];
  bit   e_dv, e_last, e_eob, e_full, e_nempty;
  int   e_data;

  int nvec = 0;
  int nbad = 0;
  int cap[$];
  int eob_pos[$];
  int last_pos[$];
  int ocnt = 0;

  // Zigzag order built by walking anti-diagonals of the 8x8 grid.
  function automatic void build_order();
    int n;
    int lo, hi;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_order[n] = r * 8 + (s - r);
          n++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_order[n] = r * 8 + (s - r);
          n++;
        end
      end
    end
  endfunction

  function automatic int last_nonzero(input blk_t b);
    int p;
    p = 0;
    for (int k = 0; k < 64; k++)
      if (b[zz_order[k]] != 0) p = k;
    return p;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit aw, ar;
    int n;
    if (rst) begin
      store.delete();
      wi = 0; ri = 0;
      e_dv = 0; e_last = 0; e_eob = 0;
      e_full = 0; e_nempty = 0; e_data = 0;
    end else begin
      n  = store.size();
      aw = bus.i_we && (n != NM);
      ar = bus.i_re && (n != 0);
      e_dv = ar; e_last = 0; e_eob = 0;
      if (ar) begin
        e_data = store[0][zz_order[ri]];
        e_last = (ri == 63);
`ifdef MATRIX_TO_ZIGZAG_EOB_EN
        e_eob  = (ri == last_nonzero(store[0]));
`endif
        ri++;
        if (ri == 64) begin
          ri = 0;
          void'(store.pop_front());
        end
      end
      if (aw) begin
        cur[wi] = int'($signed(bus.i_data));
        wi++;
        if (wi == 64) begin
          wi = 0;
          store.push_back(cur);
        end
      end
      e_full   = (store.size() == NM);
      e_nempty = (store.size() != 0);
    end
  end

  always @(negedge clk) begin
    chk("dv", int'(bus.o_dv), int'(e_dv));
    chk("full", int'(bus.o_full), int'(e_full));
    chk("nempty", int'(bus.o_nempty), int'(e_nempty));
    if (e_dv) begin
      chk("data", int'($signed(bus.o_data)), e_data);
      chk("last", int'(bus.o_last), int'(e_last));
      chk("eob", int'(bus.o_eob), int'(e_eob));
    end else begin
      chk("last_idle", int'(bus.o_last), 0);
      chk("eob_idle", int'(bus.o_eob), 0);
    end
    if (bus.o_dv === 1'b1) begin
      cap.push_back(int'($signed(bus.o_data)));
      if (bus.o_eob) eob_pos.push_back(ocnt);
      if (bus.o_last) last_pos.push_back(ocnt);
      ocnt++;
    end
  end

  task automatic step(input bit we, input int d, input bit re);
    bus.i_we   = we;
    bus.i_data = DW'(d);
    bus.i_re   = re;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap.delete();
    eob_pos.delete();
    last_pos.delete();
    ocnt = 0;
  endtask

  task automatic read_n(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
  endtask

  initial begin
    build_order();
    bus.i_we = 0; bus.i_data = '0; bus.i_re = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_full", int'(bus.o_full), 0);
    chk("rst_nempty", int'(bus.o_nempty), 0);
    chk("rst_dv", int'(bus.o_dv), 0);
    chk("rst_data", int'(bus.o_data), 0);
    chk("rst_last", int'(bus.o_last), 0);
    chk("rst_eob", int'(bus.o_eob), 0);
    rst = 0;
    step(1'b0, 0, 1'b0);

    // single block, data = raster index
    clear_cap();
    for (int i = 0; i < 63; i++) step(1'b1, i, 1'b0);
    chk("nempty_before_commit", int'(bus.o_nempty), 0);
    step(1'b1, 63, 1'b0);
    chk("nempty_after_commit", int'(bus.o_nempty), 1);
    read_n(64);
    chk("t1_count", cap.size(), 64);
    chk("t1_z0", cap[0], 0);
    chk("t1_z2", cap[2], 8);
    chk("t1_z3", cap[3], 16);
    chk("t1_z4", cap[4], 9);
    chk("t1_z9", cap[9], 24);
    chk("t1_z20", cap[20], 40);
    chk("t1_z63", cap[63], 63);
    chk("t1_nlast", last_pos.size(), 1);
    chk("t1_lastpos", last_pos[0], 63);

    // three blocks, no reads: third is dropped
    clear_cap();
    for (int b = 1; b <= 3; b++)
      for (int i = 0; i < 64; i++) begin
        step(1'b1, b * 1000 + i, 1'b0);
        if (b == 2 && i == 63)
          chk("t2_full", int'(bus.o_full), 1);
      end
    read_n(130);
    chk("t2_count", cap.size(), 128);
    chk("t2_first", cap[0], 1000);
    chk("t2_b2first", cap[64], 2000);
    chk("t2_b2z2", cap[66], 2008);
    chk("t2_end", cap[127], 2063);
    chk("t2_empty", int'(bus.o_nempty), 0);

    // continuous write and read across four blocks
    clear_cap();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 64; i++)
        step(1'b1, -(b * 300 + i), 1'b1);
    read_n(70);
    chk("t3_count", cap.size(), 256);
    chk("t3_b3z2", cap[192 + 2], -908);

    // read pulses while empty
    clear_cap();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
    end
    chk("t4_no_dv", cap.size(), 0);

    // gapped writes
    clear_cap();
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(0, 1) == 1) step(1'b0, 0, 1'b0);
      step(1'b1, i * 3 - 50, 1'b0);
    end
    read_n(64);
    chk("t5_count", cap.size(), 64);
    chk("t5_z2", cap[2], -26);
    chk("t5_z63", cap[63], 139);

    // sparse block (raster 0,1,8,17), then DC-only block
    clear_cap();
    for (int i = 0; i < 64; i++)
      step(1'b1, (i == 0 || i == 1 || i == 8 || i == 17) ? i + 5 : 0, 1'b0);
    read_n(64);
    chk("t6_z8", cap[8], 22);
`ifdef MATRIX_TO_ZIGZAG_EOB_EN
    chk("t6_neob", eob_pos.size(), 1);
    chk("t6_eobpos", eob_pos[0], 8);
`else
    chk("t6_neob", eob_pos.size(), 0);
`endif
    clear_cap();
    for (int i = 0; i < 64; i++) step(1'b1, (i == 0) ? 77 : 0, 1'b0);
    read_n(64);
`ifdef MATRIX_TO_ZIGZAG_EOB_EN
    chk("t6_dc_neob", eob_pos.size(), 1);
    chk("t6_dc_eobpos", eob_pos[0], 0);
`else
    chk("t6_dc_neob", eob_pos.size(), 0);
`endif

    // reset mid-operation
    for (int i = 0; i < 64; i++) step(1'b1, i + 7, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 500 + i, i < 10);
    rst = 1;
    #1;
    chk("mid_full", int'(bus.o_full), 0);
    chk("mid_nempty", int'(bus.o_nempty), 0);
    chk("mid_dv", int'(bus.o_dv), 0);
    chk("mid_data", int'(bus.o_data), 0);
    chk("mid_last", int'(bus.o_last), 0);
    chk("mid_eob", int'(bus.o_eob), 0);
    bus.i_we = 0; bus.i_re = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    step(1'b0, 0, 1'b0);
    clear_cap();
    for (int i = 0; i < 64; i++) step(1'b1, i * 2, 1'b0);
    read_n(64);
    chk("t7_count", cap.size(), 64);
    chk("t7_z2", cap[2], 16);
    chk("t7_z63", cap[63], 126);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
